// File: rtl/fpu_pkg.sv
// Shared FP compare types, constants and NaN classification helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_pkg;

    typedef enum logic [1:0] {
        FEQ = 2'b00,
        FLT = 2'b01,
        FLE = 2'b10
    } fcmp_op_t;

    localparam logic [7:0] EXP_MAX  = 8'd255;
    localparam int         QNAN_BIT = 22;

    // Exponent all ones with a non-zero mantissa.
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
    endfunction

    // Signalling NaN: quiet bit clear.
    function automatic logic is_snan(input logic [31:0] x);
        return is_nan(x) && !x[QNAN_BIT];
    endfunction

endpackage

// File: rtl/fcmp_core.sv
// Single-precision compare (feq/flt/fle) with invalid-operation flag.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fcmp_core (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [1:0]  op,
    output logic        y,
    output logic        nv
);
    import fpu_pkg::*;

    logic any_nan;
    logic any_snan;
    logic both_zero;
    logic mag_lt;
    logic mag_eq;
    logic lt;
    logic eq;

    // Ordering built from magnitude compare plus sign; -0 and +0 collapse to equal.
    always_comb begin
        any_nan   = is_nan(x1) || is_nan(x2);
        any_snan  = is_snan(x1) || is_snan(x2);
        both_zero = (x1[30:0] == 31'd0) && (x2[30:0] == 31'd0);
        mag_lt    = x1[30:0] < x2[30:0];
        mag_eq    = x1[30:0] == x2[30:0];
        eq        = both_zero || (mag_eq && (x1[31] == x2[31]));
        if (both_zero) begin
            lt = 1'b0;
        end else if (x1[31] != x2[31]) begin
            lt = x1[31];
        end else if (x1[31]) begin
            lt = !mag_lt && !mag_eq;
        end else begin
            lt = mag_lt;
        end

        y  = 1'b0;
        nv = 1'b0;
        if (any_nan) begin
            nv = (op == FEQ) ? any_snan : 1'b1;
        end else begin
            case (op)
                FEQ:     y = eq;
                FLT:     y = lt;
                default: y = lt || eq;
            endcase
        end
    end

endmodule

// File: rtl/fcmp_arbiter.sv
// Round-robin shares one fcmp_core among NREQ requesters; result tagged with requester id.
// Latency: 1 cycle from grant to res_valid; one result per cycle sustained.
// Backpressure: no grant while res_valid && !res_ready; a draining slot can be refilled same edge.
module fcmp_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_x1,
    input  logic [32*NREQ-1:0]   req_x2,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDW-1:0]       res_id,
    output logic                 res_y,
    output logic                 res_nv
);
    import fpu_pkg::*;

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic           free;
    logic           gnt_any;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] nxt_ptr;
    logic [IDW:0]   scan_sum;
    logic [31:0]    sel_x1;
    logic [31:0]    sel_x2;
    logic [1:0]     sel_op;
    logic           core_y;
    logic           core_nv;

    assign free    = !res_valid || res_ready;
    assign nxt_ptr = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_id   = '0;
        scan_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan_sum >= NREQ_W) begin
                scan_sum = scan_sum - NREQ_W;
            end
            if (!gnt_any && req_valid[scan_sum[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = scan_sum[IDW-1:0];
            end
        end
    end

    // One-hot ready and operand mux for the selected requester.
    always_comb begin
        req_ready = '0;
        sel_x1    = '0;
        sel_x2    = '0;
        sel_op    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                req_ready[i] = free && gnt_any;
                sel_x1       = req_x1[32*i +: 32];
                sel_x2       = req_x2[32*i +: 32];
                sel_op       = req_op[2*i +: 2];
            end
        end
    end

    fcmp_core u_core (
        .x1 (sel_x1),
        .x2 (sel_x2),
        .op (sel_op),
        .y  (core_y),
        .nv (core_nv)
    );

    // Result register: load on grant, otherwise drain on res_ready keeping payload.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_y     <= 1'b0;
            res_nv    <= 1'b0;
            rr_ptr    <= '0;
        end else if (free && gnt_any) begin
            res_valid <= 1'b1;
            res_id    <= gnt_id;
            res_y     <= core_y;
            res_nv    <= core_nv;
            rr_ptr    <= nxt_ptr;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: doc/fcmp_arbiter.md
Name: fcmp_arbiter

Overview:
- Shares one single-precision compare datapath (le/lt/eq) among NREQ requesters with per-requester valid/ready handshakes.
- Round-robin arbitration; one registered result stage with backpressure. Results are tagged with the requester index.
- Sits between the integer/FP issue slots and the FP compare logic. It replaces per-slot comparator copies.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must equal clog2(NREQ).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  requester i has a compare pending.
- req_op  input  2*NREQ  op of requester i at [2i+1:2i]: 00 feq, 01 flt, 10 fle, 11 reserved (treated as fle).
- req_x1  input  32*NREQ  operand 1 of requester i at [32i+31:32i].
- req_x2  input  32*NREQ  operand 2 of requester i.
- req_ready  output  NREQ  one-hot grant; transfer when req_valid[i] && req_ready[i].
- res_valid  output  1  result register holds a valid result.
- res_ready  input  1  consumer accepts the result.
- res_id  output  IDW  index of the requester that produced the result.
- res_y  output  1  compare result.
- res_nv  output  1  invalid-operation flag.

Behaviour:
- Reset (rstn low, asynchronous): res_valid=0, res_id=0, res_y=0, res_nv=0, rr_ptr=0.
  - req_ready is combinational and therefore 0 while res_valid=0 is forced and no req_valid is high.
- Stage can accept when free = !res_valid || res_ready.
- Grant selection:
  - When free, req_ready is one-hot on the first i with req_valid[i]=1, scanning from rr_ptr upward with wrap.
  - When not free, req_ready=0.
  - req_ready never depends on res_valid of the same requester.
- On a grant to requester g, at the next rising edge:
  - res_valid=1, res_id=g, res_y/res_nv are computed from g's operands.
  - rr_ptr = (g+1) mod NREQ.
- With no grant and res_ready=1: res_valid goes to 0 and res_y/res_nv/res_id hold their values.
  - With no grant and res_ready=0: everything holds.
- Simultaneous drain and grant (res_valid && res_ready && a new grant): the new result replaces the old one in the same edge, so throughput is 1 result per cycle.
- Latency: request accepted in cycle n, result visible in cycle n+1.
- rr_ptr advances only on a grant. An idle requester never blocks others. Starvation bound is NREQ-1 grants.
- Compare semantics, IEEE-754 single:
  - NaN: exp=255 and mant!=0. sNaN: NaN with mant[22]=0.
  - +0 and -0 compare equal for every op.
  - Denormals are compared by value. Infinities are ordered normally.
  - Sign-magnitude ordering: for two negative operands the magnitude order is reversed.
  - Any NaN operand: res_y=0.
    - flt/fle: res_nv=1 for any NaN.
    - feq: res_nv=1 only if either operand is sNaN.
  - Otherwise res_nv=0.
- Reset asserted while res_valid=1: the result is discarded and no output is produced after reset release.
- Operands and op are sampled only at the granting edge. Requesters must hold them stable while req_valid=1 and not granted.

Decomposition:
- Shared package fpu_pkg:
  - typedef fcmp_op_t, a 2-bit enum FEQ/FLT/FLE.
  - constants EXP_MAX=8'd255 and QNAN_BIT=22.
  - function is_nan and function is_snan.
- Sub-module fcmp_core (combinational): inputs x1, x2, op; outputs y, nv. It uses magnitude compare on bits [30:0] plus sign logic. It is instantiated once inside fcmp_arbiter.
- The arbiter contains the round-robin pointer, the grant logic and the result register.

Test Plan:
- Single requester 0: op=FLE, x1=0x3F800000, x2=0x40000000, res_ready=1 -> req_ready=0001 in the same cycle; next cycle res_valid=1, res_id=0, res_y=1, res_nv=0.
- Signed zeros: op=FEQ, x1=0x80000000, x2=0x00000000 -> res_y=1. op=FLT with the same operands -> res_y=0.
- NaNs:
  - FEQ x1=0x7FC00000 (qNaN) -> res_y=0, res_nv=0.
  - FEQ x1=0x7F800001 (sNaN) -> res_y=0, res_nv=1.
  - FLE x1=0x7FC00000 -> res_y=0, res_nv=1.
- Negatives: FLT x1=0xC0000000 (-2.0), x2=0xBF800000 (-1.0) -> res_y=1. Swapped operands -> res_y=0.
- All 4 requesters valid continuously, res_ready=1, from reset -> grants 0,1,2,3,0,... one per cycle; res_id follows one cycle later.
- Backpressure and reset:
  - res_ready=0 for 3 cycles with 2 requesters valid -> req_ready=0, res_* stable; on res_ready=1 the next grant issues in the same cycle.
  - rstn pulsed low mid-burst -> res_valid=0 immediately; after release the first grant goes to requester 0.
